// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: serialises one pipeline step's data access and
// instruction fetch (data first), freezing the pipeline until both complete.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              readMem,
   input  logic              writeMem,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              stop,
   output logic              bus_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DATA  = 2'd1;
   localparam logic [1:0] S_FETCH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   // Abort fires on the cycle whose missing ack would bring the count to TIMEOUT.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [1:0]        state_reg;
   logic [CNT_W-1:0]  wait_cnt_reg;
   logic              d_done_reg;
   logic              i_done_reg;
   logic              err_reg;
   logic              mem_we_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic [DATA_W-1:0] mem_wdata_reg;
   logic [DATA_W-1:0] if_rdata_reg;
   logic [DATA_W-1:0] dm_rdata_reg;

   logic              start_data;
   logic              start_fetch;
   logic              in_access;
   logic              timed_out;
   logic              access_end;
   logic [DATA_W-1:0] access_data;

   always_comb begin
      start_data  = (readMem | writeMem) & ~d_done_reg;
      start_fetch = if_req & ~i_done_reg;
      in_access   = (state_reg == S_DATA) || (state_reg == S_FETCH);
      timed_out   = (TIMEOUT != 0) && in_access && !mem_ack && (wait_cnt_reg == CNT_LAST);
      access_end  = in_access && (mem_ack || timed_out);
      access_data = timed_out ? '0 : mem_rdata;
   end

   // stop is forced low during reset even though IDLE would otherwise follow the requests.
   assign stop      = rst && ((state_reg == S_IDLE) ? (start_data | start_fetch) : in_access);
   assign mem_req   = in_access;
   assign bus_err   = (state_reg == S_DONE) && err_reg;
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign if_rdata  = if_rdata_reg;
   assign dm_rdata  = dm_rdata_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= S_IDLE;
         wait_cnt_reg  <= '0;
         d_done_reg    <= 1'b0;
         i_done_reg    <= 1'b0;
         err_reg       <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         if_rdata_reg  <= '0;
         dm_rdata_reg  <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start_data) begin
                  state_reg     <= S_DATA;
                  mem_addr_reg  <= dm_addr;
                  mem_wdata_reg <= dm_wdata;
                  mem_we_reg    <= writeMem;
                  wait_cnt_reg  <= '0;
               end else if (start_fetch) begin
                  state_reg    <= S_FETCH;
                  mem_addr_reg <= if_addr;
                  mem_we_reg   <= 1'b0;
                  wait_cnt_reg <= '0;
               end
            end
            S_DATA: begin
               if (access_end) begin
                  d_done_reg <= 1'b1;
                  err_reg    <= err_reg | timed_out;
                  // A store has no read target, so dm_rdata keeps the last load.
                  if (!mem_we_reg) begin
                     dm_rdata_reg <= access_data;
                  end
                  if (start_fetch) begin
                     state_reg    <= S_FETCH;
                     mem_addr_reg <= if_addr;
                     mem_we_reg   <= 1'b0;
                     wait_cnt_reg <= '0;
                  end else begin
                     state_reg <= S_DONE;
                  end
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
            end
            S_FETCH: begin
               if (access_end) begin
                  i_done_reg   <= 1'b1;
                  err_reg      <= err_reg | timed_out;
                  if_rdata_reg <= access_data;
                  state_reg    <= S_DONE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
            end
            default: begin
               state_reg    <= S_IDLE;
               d_done_reg   <= 1'b0;
               i_done_reg   <= 1'b0;
               err_reg      <= 1'b0;
               wait_cnt_reg <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random and directed pipeline steps,
// a memory responder/access monitor and a step-result monitor.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          if_req, readMem, writeMem;
   logic [AW-1:0] if_addr, dm_addr, mem_addr;
   logic [DW-1:0] dm_wdata, if_rdata, dm_rdata, mem_wdata, mem_rdata;
   logic          stop, bus_err, mem_req, mem_we, mem_ack;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .readMem(readMem), .writeMem(writeMem), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
      .stop(stop), .bus_err(bus_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} acc_t;
   typedef struct {int dly; logic [31:0] data;} plan_t;
   typedef struct {logic [31:0] dm; logic [31:0] ifd; logic err; int cyc;} step_t;

   acc_t  exp_acc_q[$];
   plan_t plan_q[$];
   step_t exp_step_q[$];

   int          checks = 0;
   int          passes = 0;
   logic [31:0] dm_model = '0;
   logic [31:0] if_model = '0;
   bit          resp_en = 1'b0;
   bit          mon_en = 1'b0;
   bit          stray_ack = 1'b0;
   logic [31:0] stray_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: actual=%h required=%h", name, act, exp);
   endtask

   // Memory responder; also checks each access the DUT presents.
   initial begin : responder
      bit    serving;
      int    cnt;
      plan_t p;
      acc_t  a;
      serving = 1'b0;
      cnt = 0;
      p.dly = 0;
      p.data = '0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!resp_en) begin
            serving = 1'b0;
            mem_ack = stray_ack;
            mem_rdata = stray_data;
         end else begin
            if (!serving && mem_req) begin
               serving = 1'b1;
               cnt = 0;
               if (plan_q.size() > 0) p = plan_q.pop_front();
               else begin p.dly = 0; p.data = '0; end
               if (exp_acc_q.size() > 0) begin
                  a = exp_acc_q.pop_front();
                  $display("ACC addr=%h we=%0d wdata=%h dly=%0d", mem_addr, mem_we, mem_wdata, p.dly);
                  chk("acc_addr", mem_addr, a.addr);
                  chk("acc_we", 32'(mem_we), 32'(a.we));
                  if (a.we) chk("acc_wdata", mem_wdata, a.wdata);
               end else begin
                  checks++;
                  $display("FAIL acc_unexpected: actual=access at %h required=none", mem_addr);
               end
            end
            if (serving) begin
               if (cnt == p.dly && p.dly < TO) begin
                  mem_ack = 1'b1;
                  mem_rdata = p.data;
                  serving = 1'b0;
               end else begin
                  mem_ack = 1'b0;
                  mem_rdata = $urandom;
                  cnt++;
                  if (cnt >= TO) serving = 1'b0;
               end
            end else begin
               mem_ack = 1'b0;
            end
         end
      end
   end

   // Step monitor: a falling stop marks the DONE cycle carrying the step result.
   initial begin : monitor
      bit    prev_stop;
      int    cyc;
      step_t e;
      prev_stop = 1'b0;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            prev_stop = 1'b0;
            cyc = 0;
         end else begin
            if (prev_stop && !stop) begin
               if (exp_step_q.size() > 0) begin
                  e = exp_step_q.pop_front();
                  $display("STEP dm=%h if=%h err=%0d stop_cycles=%0d", dm_rdata, if_rdata, bus_err, cyc);
                  chk("step_dm_rdata", dm_rdata, e.dm);
                  chk("step_if_rdata", if_rdata, e.ifd);
                  chk("step_bus_err", 32'(bus_err), 32'(e.err));
                  chk("step_stop_cycles", 32'(cyc), 32'(e.cyc));
               end else begin
                  checks++;
                  $display("FAIL step_unexpected: actual=step end required=none");
               end
               cyc = 0;
            end else if (bus_err) begin
               checks++;
               $display("FAIL bus_err_stray: actual=1 required=0");
            end
            if (stop) cyc++;
            prev_stop = stop;
         end
      end
   end

   // Reference model of one step, then drive it and wait for the freeze to lift.
   task automatic do_step(input bit rd, input bit wr, input bit ifr,
                          input logic [31:0] daddr, input logic [31:0] wdata,
                          input logic [31:0] iaddr,
                          input int d0, input logic [31:0] r0,
                          input int d1, input logic [31:0] r1);
      int cyc;
      bit err;
      bit any;
      int n;
      cyc = 1;
      err = 1'b0;
      any = rd | wr | ifr;
      if (rd | wr) begin
         exp_acc_q.push_back('{daddr, wr, wdata});
         plan_q.push_back('{d0, r0});
         if (d0 >= TO) begin
            cyc += TO;
            err = 1'b1;
            if (!wr) dm_model = '0;
         end else begin
            cyc += d0 + 1;
            if (!wr) dm_model = r0;
         end
      end
      if (ifr) begin
         exp_acc_q.push_back('{iaddr, 1'b0, 32'h0});
         plan_q.push_back('{d1, r1});
         if (d1 >= TO) begin
            cyc += TO;
            err = 1'b1;
            if_model = '0;
         end else begin
            cyc += d1 + 1;
            if_model = r1;
         end
      end
      if (any) exp_step_q.push_back('{dm_model, if_model, err, cyc});
      @(posedge clk);
      #1;
      readMem = rd; writeMem = wr; if_req = ifr;
      dm_addr = daddr; dm_wdata = wdata; if_addr = iaddr;
      if (!any) begin
         @(negedge clk);
         chk("idle_stop", 32'(stop), 32'h0);
         chk("idle_mem_req", 32'(mem_req), 32'h0);
         return;
      end
      n = 0;
      @(negedge clk);
      while (stop && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (stop) begin
         checks++;
         $display("FAIL step_hang: actual=stop still 1 after %0d cycles required=0", n);
      end
      @(posedge clk);
      #1;
      readMem = 1'b0; writeMem = 1'b0; if_req = 1'b0;
   endtask

   initial begin : stimulus
      if_req = 1'b0; readMem = 1'b0; writeMem = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      if_req = 1'b1; readMem = 1'b1;
      #1;
      chk("rst_stop", 32'(stop), 32'h0);
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_bus_err", 32'(bus_err), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_dm_rdata", dm_rdata, 32'h0);
      if_req = 1'b0; readMem = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      mon_en = 1'b1;
      resp_en = 1'b1;

      do_step(0, 0, 1, 32'h0, 32'h0, 32'h40, 0, 32'h0, 2, 32'h20080005);
      do_step(1, 0, 1, 32'h100, 32'h0, 32'h44, 0, 32'h11, 0, 32'h22);
      do_step(1, 1, 0, 32'h400, 32'hCAFEF00D, 32'h0, 1, 32'h77, 0, 32'h0);
      do_step(0, 1, 0, 32'h200, 32'hDEADBEEF, 32'h0, 0, 32'h0, 0, 32'h0);
      do_step(1, 0, 0, 32'h300, 32'h0, 32'h0, 100, 32'h55, 0, 32'h0);

      for (int k = 0; k < 40; k++) begin
         int sel;
         bit ifr;
         int d0, d1;
         sel = int'($urandom_range(0, 3));
         ifr = ($urandom_range(0, 3) != 0);
         d0 = ($urandom_range(0, 4) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
         d1 = ($urandom_range(0, 4) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
         do_step(sel == 1 || sel == 3, sel >= 2, ifr, $urandom, $urandom, $urandom,
                 d0, $urandom, d1, $urandom);
      end

      // Reset asserted mid-fetch, then a stray ack after release.
      mon_en = 1'b0;
      resp_en = 1'b0;
      stray_ack = 1'b0;
      @(posedge clk);
      #1;
      if_req = 1'b1; if_addr = 32'h80;
      @(posedge clk);
      #3;
      chk("t5_req_before_rst", 32'(mem_req), 32'h1);
      rst = 1'b0;
      #1;
      chk("t5_req_async_drop", 32'(mem_req), 32'h0);
      chk("t5_stop_async_drop", 32'(stop), 32'h0);
      @(posedge clk);
      #1;
      if_req = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      stray_ack = 1'b1;
      stray_data = 32'hBADBAD00;
      @(posedge clk);
      #1;
      stray_ack = 1'b0;
      chk("t5_stray_mem_req", 32'(mem_req), 32'h0);
      chk("t5_stray_stop", 32'(stop), 32'h0);
      chk("t5_stray_if_rdata", if_rdata, 32'h0);
      chk("t5_stray_dm_rdata", dm_rdata, 32'h0);
      dm_model = '0;
      if_model = '0;
      mon_en = 1'b1;
      resp_en = 1'b1;
      do_step(0, 0, 1, 32'h0, 32'h0, 32'h84, 1, 32'h13572468, 0, 32'h0);
      do_step(1, 0, 1, 32'h500, 32'h0, 32'h88, 2, 32'hA5A5A5A5, 5, 32'h1);

      repeat (5) @(posedge clk);
      chk("left_acc_q", 32'(exp_acc_q.size()), 32'h0);
      chk("left_step_q", 32'(exp_step_q.size()), 32'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
